gcd_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one GCD datapath/controller pair (the "core") among `N_REQ` requesters. It captures one requester's operand pair and drives the core's `go`/`done` four-phase handshake. It returns the result with a one-cycle acknowledge, and resolves zero-operand requests locally because the subtractive core never converges on them. It sits between client logic and the GCD core, and is the only block that drives the core's `go`.

---
 rtl/gcd_rr_arbiter_pkg.sv | 19 +
 rtl/gcd_core.sv | 63 ++++++
 rtl/gcd_rr_arbiter_rr_pick.sv | 44 ++++
 rtl/gcd_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_gcd_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_rr_arbiter_pkg.sv
// gcd_pkg: shared types for the round-robin GCD arbiter and the GCD core.
//   arb_state_t  - arbiter sequencer states
//   core_state_t - subtractive GCD core states
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    BYPASS = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE = 2'd0,
    CORE_CALC = 2'd1,
    CORE_DONE = 2'd2
  } core_state_t;

endpackage

// File: rtl/gcd_core.sv
// gcd_core: subtractive GCD datapath/controller with a four-phase go/done
// handshake. Operands are loaded when go is seen in CORE_IDLE; done stays
// high until go drops. Zero operands never converge and must not be issued.
//   clk, rst  - clock, synchronous active-high reset
//   go        - start request (held until done)
//   x, y      - operands, sampled at start
//   done      - result valid, held until go falls
//   result    - gcd(x, y)
//   state_dbg - controller state
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output core_state_t      state_dbg
);

  core_state_t      state, state_next;
  logic [WIDTH-1:0] ra, rb;

  always_comb begin
    state_next = state;
    case (state)
      CORE_IDLE: if (go) state_next = CORE_CALC;
      CORE_CALC: if (ra == rb) state_next = CORE_DONE;
      CORE_DONE: if (!go) state_next = CORE_IDLE;
      default:   state_next = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CORE_IDLE;
      ra    <= '0;
      rb    <= '0;
    end else begin
      state <= state_next;
      case (state)
        CORE_IDLE: if (go) begin
          ra <= x;
          rb <= y;
        end
        CORE_CALC: begin
          if (ra > rb)      ra <= ra - rb;
          else if (rb > ra) rb <= rb - ra;
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == CORE_DONE);
  assign result    = ra;
  assign state_dbg = state;

endmodule

// File: rtl/gcd_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector
//   ptr   - highest-priority index (search starts here, wraps modulo N_REQ)
//   valid - any request present
//   idx   - first set request at or after ptr
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotating the request vector right by ptr puts ptr at bit 0, so the
  // lowest set bit of rotated is the offset of the winner from ptr.
  assign doubled = {req, req} >> ptr;
  assign rotated = doubled[N_REQ-1:0];

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  // ptr + off can exceed N_REQ-1 when N_REQ is not a power of two.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: round-robin sequencer sharing one GCD core among N_REQ
// requesters. Zero-operand requests are answered locally (a | b).
//   clk, rst          - clock, synchronous active-high reset
//   req               - request levels, held until ack
//   a_in, b_in        - packed operands, slice i = [i*WIDTH +: WIDTH]
//   ack               - one-hot, one-cycle completion pulse
//   result            - GCD of acknowledged request, held until next ack
//   busy              - arbiter not in IDLE
//   grant_id          - index of request in service
//   core_go           - go to the core
//   core_x, core_y    - core operands (captured op_a/op_b)
//   core_done         - done from the core
//   core_result       - core result
//   state_dbg         - sequencer state
//
// Core handshake (four-phase): core_go rises in RUN and stays high until
// core_done is seen; core_go then falls (DRAIN) and the arbiter waits for
// core_done to fall before starting another transaction. core_x/core_y are
// stable for the whole time core_go is high.
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   core_go,
  output logic [WIDTH-1:0]       core_x,
  output logic [WIDTH-1:0]       core_y,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result,
  output arb_state_t             state_dbg
);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] rr_ptr, next_ptr;
  logic [WIDTH-1:0] op_a, op_b;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_a, pick_b;
  logic [N_REQ-1:0] grant_onehot;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_a = a_in[i*WIDTH +: WIDTH];
        pick_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr     = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
  assign grant_onehot = N_REQ'(1) << grant_id;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (pick_valid) state_next = (pick_a == '0 || pick_b == '0) ? BYPASS : RUN;
      RUN:    if (core_done) state_next = DRAIN;
      DRAIN:  if (!core_done) state_next = IDLE;
      BYPASS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_b     <= '0;
      ack      <= '0;
      result   <= '0;
    end else begin
      state <= state_next;
      ack   <= '0;
      case (state)
        IDLE: if (pick_valid) begin
          grant_id <= pick_idx;
          op_a     <= pick_a;
          op_b     <= pick_b;
        end
        RUN: if (core_done) begin
          result <= core_result;
          ack    <= grant_onehot;
        end
        DRAIN: if (!core_done) rr_ptr <= next_ptr;
        BYPASS: begin
          // gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0
          result <= op_a | op_b;
          ack    <= grant_onehot;
          rr_ptr <= next_ptr;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign core_go   = (state == RUN);
  assign core_x    = op_a;
  assign core_y    = op_b;
  assign state_dbg = state;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
module tb_gcd_rr_arbiter;
  import gcd_pkg::*;

  localparam int N = 4;
  localparam int W = 16;
  localparam int IW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req  = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           core_go;
  logic [W-1:0]   core_x, core_y;
  logic           core_done;
  logic [W-1:0]   core_result;
  arb_state_t     state_dbg;
  core_state_t    core_state;

  gcd_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .ack         (ack),
    .result      (result),
    .busy        (busy),
    .grant_id    (grant_id),
    .core_go     (core_go),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_done   (core_done),
    .core_result (core_result),
    .state_dbg   (state_dbg)
  );

  gcd_core #(.WIDTH(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .go        (core_go),
    .x         (core_x),
    .y         (core_y),
    .done      (core_done),
    .result    (core_result),
    .state_dbg (core_state)
  );

  // ---------------- scoreboard ----------------
  int vec_count  = 0;
  int miss_count = 0;
  logic [N+W-1:0] exp_q[$];   // {one-hot ack, result}
  logic keep_req = 1'b0;
  int   go_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] r);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    exp_q.push_back({oh, r});
  endtask

  // Watches for acks at negedges, compares each against the queue head and
  // drops the acked request (or all requests on the last ack when held).
  task automatic wait_acks(input int n, input int budget, output int cycles);
    int got;
    logic [N+W-1:0] e;
    got = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (core_go) go_cnt++;
      if (ack !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_id", 32'(ack), 32'(e[N+W-1:W]));
          check("ack_result", 32'(result), 32'(e[W-1:0]));
        end
        got++;
        if (!keep_req) req = req & ~ack;
        else if (got == n) req = '0;
      end
    end
    check("acks_within_budget", 32'(got), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_within_budget", 32'(busy), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    logic [N-1:0] ack_acc;

    // Reset values
    reset_dut();
    check("rst_ack", 32'(ack), 0);
    check("rst_result", 32'(result), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_core_go", 32'(core_go), 0);
    check("rst_core_x", 32'(core_x), 0);
    check("rst_core_y", 32'(core_y), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_core_state", 32'(core_state), 32'(CORE_IDLE));

    // Single requester (12,18) -> 6
    set_req(0, 16'd12, 16'd18);
    push_exp(0, 16'd6);
    @(negedge clk);
    check("single_busy", 32'(busy), 1);
    check("single_grant", 32'(grant_id), 0);
    check("single_state", 32'(state_dbg), 32'(RUN));
    check("single_go", 32'(core_go), 1);
    check("single_x", 32'(core_x), 12);
    check("single_y", 32'(core_y), 18);
    wait_acks(1, 200, cyc);
    check("single_go_low_after_ack", 32'(core_go), 0);
    wait_idle(20);
    check("single_go_idle", 32'(core_go), 0);

    // Simultaneous req0 (48,36) and req2 (7,5), ptr = 0
    reset_dut();
    set_req(0, 16'd48, 16'd36);
    set_req(2, 16'd7, 16'd5);
    push_exp(0, 16'd12);
    push_exp(2, 16'd1);
    wait_acks(2, 400, cyc);
    wait_idle(20);

    // All four held for 8 grants: 0,1,2,3,0,1,2,3
    reset_dut();
    set_req(0, 16'd6, 16'd4);
    set_req(1, 16'd9, 16'd6);
    set_req(2, 16'd10, 16'd15);
    set_req(3, 16'd14, 16'd21);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 16'd2);
      push_exp(1, 16'd3);
      push_exp(2, 16'd5);
      push_exp(3, 16'd7);
    end
    keep_req = 1'b1;
    wait_acks(8, 2000, cyc);
    keep_req = 1'b0;
    wait_idle(20);
    check("rr_queue_drained", 32'(exp_q.size()), 0);

    // Zero operand bypass: req1 (0,9) -> 9, ptr is back at 0
    go_cnt = 0;
    set_req(1, 16'd0, 16'd9);
    push_exp(1, 16'd9);
    @(negedge clk);
    check("bypass_grant", 32'(grant_id), 1);
    check("bypass_state", 32'(state_dbg), 32'(BYPASS));
    check("bypass_go", 32'(core_go), 0);
    wait_acks(1, 20, cyc);
    check("bypass_latency", 32'(cyc), 1);
    check("bypass_no_go", 32'(go_cnt), 0);

    // req3 (0,0) -> 0
    @(negedge clk);
    set_req(3, 16'd0, 16'd0);
    push_exp(3, 16'd0);
    @(negedge clk);
    check("zero_zero_grant", 32'(grant_id), 3);
    wait_acks(1, 20, cyc);
    check("zero_zero_no_go", 32'(go_cnt), 0);
    wait_idle(20);

    // Reset during RUN on (1000,3): no ack, then (10,4) -> 2
    set_req(0, 16'd1000, 16'd3);
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("midrun_go_before_rst", 32'(core_go), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("midrun_rst_go", 32'(core_go), 0);
    check("midrun_rst_state", 32'(state_dbg), 32'(IDLE));
    check("midrun_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    ack_acc = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ack_acc = ack_acc | ack;
    end
    check("midrun_no_ack", 32'(ack_acc), 0);
    set_req(0, 16'd10, 16'd4);
    push_exp(0, 16'd2);
    wait_acks(1, 200, cyc);
    wait_idle(20);

    // Operands change after grant and req withdrawn mid-RUN: (35,21) -> 7
    set_req(2, 16'd35, 16'd21);
    push_exp(2, 16'd7);
    @(negedge clk);
    check("late_grant", 32'(grant_id), 2);
    a_in[2*W +: W] = 16'd100;
    b_in[2*W +: W] = 16'd50;
    @(negedge clk);
    req[2] = 1'b0;
    check("late_core_x", 32'(core_x), 35);
    check("late_core_y", 32'(core_y), 21);
    wait_acks(1, 200, cyc);
    wait_idle(20);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
